vga_sync_decoder: RTL

- Receive-side counterpart of the VGA timing generator: takes incoming active-low hsync/vsync on the pixel clock and recovers pixel coordinates, display enable and a frame-start strobe.
- Measures line and frame lengths, and asserts locked after consecutive conforming frames.
- Sits between a VGA timing source (internal generator loopback or capture path) and pixel consumers such as the board renderer, checkers and test monitors.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 26 ++
 rtl/vga_sync_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and lock state encoding, shared by the
// VGA timing generator and the sync decoder.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_FP     = 16;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_FP     = 10;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers an active-low sync input plus one delay stage; lead pulses for one
// cycle on the 1->0 transition of the registered copy. No backpressure.
module sync_edge_detect (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic sync_n,
  output logic lead
);

  logic sync_q;
  logic sync_d;

  // Idle level of an active-low sync is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync_q <= sync_n;
      sync_d <= sync_q;
    end
  end

  assign lead = sync_d & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, display enable and lock from incoming hsync/vsync.
// 3-cycle pin-to-de/x/y latency; no backpressure, pixel stream is free-running.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas,
  output logic [7:0]  err_count
);

  import vga_timing_pkg::*;

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_STOP  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_STOP  = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [10:0] H_TMO   = 11'(2 * H_TOTAL);
  localparam logic [10:0] POS_MAX = 11'h7FF;
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  logic        h_lead;
  logic        v_lead;
  logic        v_lead_d;
  logic [10:0] h_pos;
  logic [10:0] v_pos;
  logic [10:0] h_len;
  logic [10:0] v_len;
  logic        h_seen;
  logic        h_timeout;
  logic        bad_line;
  logic        bad_frame;
  logic        violation;
  logic        de_nxt;

  lock_state_t state;
  lock_state_t state_nxt;
  logic [7:0]  good_frames;
  logic [7:0]  good_nxt;
  logic        line_ok;
  logic        line_ok_nxt;

  sync_edge_detect u_hsync_edge (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .sync_n    (hsync_n),
    .lead      (h_lead)
  );

  sync_edge_detect u_vsync_edge (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .sync_n    (vsync_n),
    .lead      (v_lead)
  );

  assign h_len     = h_pos + 11'd1;
  assign v_len     = v_pos + 11'd1;
  // The first hsync edge after reset closes a partial line and is not judged.
  assign h_timeout = !h_lead && (h_pos == H_TMO);
  assign bad_line  = (h_lead && h_seen && (h_len != H_LEN)) || h_timeout;
  assign bad_frame = v_lead && (v_len != V_LEN);

  always_comb begin
    state_nxt   = state;
    good_nxt    = good_frames;
    line_ok_nxt = line_ok;
    violation   = 1'b0;
    case (state)
      SEARCH: begin
        if (v_lead) begin
          state_nxt   = VERIFY;
          good_nxt    = '0;
          line_ok_nxt = 1'b1;
        end
      end
      VERIFY: begin
        violation = bad_line || bad_frame;
        if (bad_line) line_ok_nxt = 1'b0;
        if (v_lead) begin
          if (line_ok && !bad_line && !bad_frame) begin
            good_nxt    = good_frames + 8'd1;
            line_ok_nxt = 1'b1;
            if (good_nxt >= LOCK_N) state_nxt = LOCKED;
          end else begin
            state_nxt = SEARCH;
          end
        end
      end
      LOCKED: begin
        violation = bad_line || bad_frame;
        if (violation) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign de_nxt = (state == LOCKED) &&
                  (h_pos >= H_START) && (h_pos < H_STOP) &&
                  (v_pos >= V_START) && (v_pos < V_STOP);

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      good_frames <= '0;
      line_ok     <= 1'b0;
      h_pos       <= '0;
      v_pos       <= '0;
      h_seen      <= 1'b0;
      v_lead_d    <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      err_count   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      state       <= state_nxt;
      good_frames <= good_nxt;
      line_ok     <= line_ok_nxt;

      if (h_lead)                h_pos <= '0;
      else if (h_pos != POS_MAX) h_pos <= h_pos + 11'd1;

      // A coincident vsync edge restarts the frame rather than advancing a line.
      if (v_lead)                          v_pos <= '0;
      else if (h_lead && v_pos != POS_MAX) v_pos <= v_pos + 11'd1;

      if (h_lead)           h_seen <= 1'b1;
      if (h_lead && h_seen) h_meas <= h_len;
      if (v_lead)           v_meas <= v_len;

      if (violation && err_count != 8'hFF) err_count <= err_count + 8'd1;

      locked      <= (state_nxt == LOCKED);
      v_lead_d    <= v_lead;
      frame_start <= v_lead_d && (state == LOCKED);
      de          <= de_nxt;
      x           <= de_nxt ? 10'(h_pos - H_START) : '0;
      y           <= de_nxt ? 10'(v_pos - V_START) : '0;
    end
  end

endmodule
